// File: rtl/laser_pattern_gen_pkg.sv
// Shared constants for the car-counter laser interface: FSM state encodings,
// beam patterns and direction codes, plus the phase-to-pattern lookup.
package laser_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PH1  = 3'd1,
        S_PH2  = 3'd2,
        S_PH3  = 3'd3,
        S_GAP  = 3'd4
    } laser_state_e;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PH1  = 3'd1;
    localparam logic [2:0] ST_PH2  = 3'd2;
    localparam logic [2:0] ST_PH3  = 3'd3;
    localparam logic [2:0] ST_GAP  = 3'd4;

    // bit0 = beam A, bit1 = beam B
    localparam logic [1:0] LAS_NONE = 2'b00;
    localparam logic [1:0] LAS_A    = 2'b01;
    localparam logic [1:0] LAS_AB   = 2'b11;
    localparam logic [1:0] LAS_B    = 2'b10;

    localparam logic DIR_ENTRY = 1'b0;
    localparam logic DIR_EXIT  = 1'b1;

    // Entry breaks A first, exit breaks B first; both pass through AB.
    function automatic logic [1:0] phase_pattern(input logic dir, input logic [2:0] st);
        logic [1:0] pat;
        pat = LAS_NONE;
        case (st)
            ST_PH1:  pat = (dir == DIR_EXIT) ? LAS_B : LAS_A;
            ST_PH2:  pat = LAS_AB;
            ST_PH3:  pat = (dir == DIR_EXIT) ? LAS_A : LAS_B;
            default: pat = LAS_NONE;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/laser_pattern_gen_timer.sv
// Loadable down-counter: expired is high while the count sits at zero.
// Holds at zero rather than wrapping.
module phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/laser_pattern_gen.sv
// Laser beam pattern generator: emits bursts of entry/exit car sequences on
// the 2-bit lasers bus, each phase held for a programmable dwell.
module laser_pattern_gen
    import laser_pkg::*;
#(
    parameter int DWELL_W = 8,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               dir,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [CNT_W-1:0]   count,
    input  logic               abort,
    output logic [1:0]         lasers,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   cars_sent,
    output logic [2:0]         state_dbg
);

    // Request protocol: start is a level sampled only in IDLE; busy stays high
    // for the whole burst, done pulses one cycle on normal completion only.
    logic [2:0]         state;
    logic               dir_q;
    logic [DWELL_W-1:0] d_m1_q;
    logic [CNT_W-1:0]   count_q;
    logic [DWELL_W-1:0] start_d_m1;
    logic [DWELL_W-1:0] timer_val;
    logic [CNT_W-1:0]   cars_next;
    logic               accept;
    logic               advance;
    logic               timer_load;
    logic               expired;

    always_comb begin
        // A dwell of 0 behaves as 1, i.e. reload value 0.
        start_d_m1 = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
        accept     = (state == ST_IDLE) && start && !abort;
        advance    = (state != ST_IDLE) && !abort && expired;
        cars_next  = cars_sent + CNT_W'(1);
        timer_load = (accept && (count != '0)) || advance;
        timer_val  = accept ? start_d_m1 : d_m1_q;
    end

    phase_timer #(
        .W(DWELL_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .expired  (expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            lasers    <= LAS_NONE;
            busy      <= 1'b0;
            done      <= 1'b0;
            cars_sent <= '0;
            dir_q     <= DIR_ENTRY;
            d_m1_q    <= '0;
            count_q   <= '0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                if (accept) begin
                    cars_sent <= '0;
                    dir_q     <= dir;
                    d_m1_q    <= start_d_m1;
                    count_q   <= count;
                    if (count == '0) begin
                        done <= 1'b1;
                    end else begin
                        state  <= ST_PH1;
                        busy   <= 1'b1;
                        lasers <= phase_pattern(dir, ST_PH1);
                    end
                end
            end else if (abort) begin
                // Abort beats a GAP completion on the same edge.
                state  <= ST_IDLE;
                lasers <= LAS_NONE;
                busy   <= 1'b0;
            end else if (expired) begin
                case (state)
                    ST_PH1: begin
                        state  <= ST_PH2;
                        lasers <= phase_pattern(dir_q, ST_PH2);
                    end
                    ST_PH2: begin
                        state  <= ST_PH3;
                        lasers <= phase_pattern(dir_q, ST_PH3);
                    end
                    ST_PH3: begin
                        state  <= ST_GAP;
                        lasers <= LAS_NONE;
                    end
                    ST_GAP: begin
                        cars_sent <= cars_next;
                        if (cars_next == count_q) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state  <= ST_PH1;
                            lasers <= phase_pattern(dir_q, ST_PH1);
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        lasers <= LAS_NONE;
                        busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_laser_pattern_gen.sv
// Directed bench for laser_pattern_gen: per-cycle expected outputs are queued
// from a reference model at each start and compared on the falling edge.
module tb_laser_pattern_gen;

    logic       clk;
    logic       rst;
    logic       start;
    logic       dir;
    logic [7:0] dwell;
    logic [7:0] count;
    logic       abort;
    logic [1:0] lasers;
    logic       busy;
    logic       done;
    logic [7:0] cars_sent;
    logic [2:0] state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    int last_cars = 0;

    logic [11:0] exp_q[$];

    // Independent sequence decoder standing in for the counter FSM.
    logic       dec_en = 1'b0;
    logic [1:0] dec_prev = 2'b00;
    logic [1:0] dec_h1 = 2'b00;
    logic [1:0] dec_h2 = 2'b00;
    int         dec_cnt = 0;

    laser_pattern_gen #(
        .DWELL_W(8),
        .CNT_W  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dir       (dir),
        .dwell     (dwell),
        .count     (count),
        .abort     (abort),
        .lasers    (lasers),
        .busy      (busy),
        .done      (done),
        .cars_sent (cars_sent),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    always @(negedge clk) begin
        if (dec_en && lasers !== dec_prev) begin
            if (lasers == 2'b00) begin
                if ({dec_h2, dec_h1, dec_prev} == 6'b01_11_10) dec_cnt++;
                else if ({dec_h2, dec_h1, dec_prev} == 6'b10_11_01 && dec_cnt > 0) dec_cnt--;
            end
            dec_h2   = dec_h1;
            dec_h1   = dec_prev;
            dec_prev = lasers;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] pat(input logic d, input int ph);
        logic [1:0] p;
        case (ph)
            0: p = d ? 2'b10 : 2'b01;
            1: p = 2'b11;
            2: p = d ? 2'b01 : 2'b10;
            default: p = 2'b00;
        endcase
        return p;
    endfunction

    // Call just after a falling edge. Vector is {done, busy, lasers, cars_sent}.
    task automatic run_burst(input string tag, input logic d, input int dw, input int cnt,
                             input int abort_at, input int glitch_at);
        int dd, total, n, cars_at_abort;
        logic [11:0] e, obs;
        dd            = (dw == 0) ? 1 : dw;
        total         = cnt * 4 * dd;
        n             = (abort_at >= 0) ? abort_at + 2 : total + 2;
        cars_at_abort = (abort_at > 0) ? (abort_at - 1) / (4 * dd) : 0;
        for (int i = 0; i < n; i++) begin
            if (abort_at >= 0 && i >= abort_at)
                e = {1'b0, 1'b0, 2'b00, 8'(cars_at_abort)};
            else if (i < total)
                e = {1'b0, 1'b1, pat(d, (i % (4 * dd)) / dd), 8'(i / (4 * dd))};
            else if (i == total)
                e = {1'b1, 1'b0, 2'b00, 8'(cnt)};
            else
                e = {1'b0, 1'b0, 2'b00, 8'(cnt)};
            exp_q.push_back(e);
        end
        last_cars = (abort_at >= 0) ? cars_at_abort : cnt;
        dir   = d;
        dwell = 8'(dw);
        count = 8'(cnt);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dir   = 1'($urandom_range(0, 1));
        dwell = 8'($urandom_range(0, 255));
        count = 8'($urandom_range(0, 255));
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            obs = {done, busy, lasers, cars_sent};
            e   = exp_q.pop_front();
            check($sformatf("%s cyc%0d", tag, i), 32'(obs), 32'(e));
            abort = (i + 1 == abort_at);
            if (i + 1 == glitch_at) begin
                start = 1'b1;
                dir   = 1'b1;
                count = 8'd9;
            end else begin
                start = 1'b0;
            end
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        dir   = 1'b0;
        dwell = 8'd0;
        count = 8'd0;
        abort = 1'b0;
        #2;
        check("reset outs", 32'({done, busy, lasers, cars_sent}), 32'd0);
        check("reset state", 32'(state_dbg), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_burst("t1 entry d3 c1", 1'b0, 3, 1, -1, -1);
        run_burst("t2 exit d2 c3", 1'b1, 2, 3, -1, -1);
        run_burst("t3 dwell0 c2", 1'b0, 0, 2, -1, -1);
        run_burst("t4 abort ph3", 1'b0, 4, 2, 10, -1);
        run_burst("t4 after abort", 1'b1, 2, 1, -1, -1);
        run_burst("abort on gap end", 1'b0, 2, 2, 8, -1);
        run_burst("t5 restart ignored", 1'b0, 2, 2, -1, 5);
        run_burst("t5 count0", 1'b1, 5, 0, -1, -1);
        run_burst("dwell max", 1'b1, 255, 1, -1, -1);

        // start together with abort in IDLE: start is dropped
        start = 1'b1;
        abort = 1'b1;
        dir   = 1'b0;
        dwell = 8'd1;
        count = 8'd3;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            check($sformatf("start+abort idle cyc%0d", i),
                  32'({done, busy, lasers, cars_sent}), 32'({4'b0000, 8'(last_cars)}));
        end

        // async reset in the middle of car 2, PH2
        dir   = 1'b0;
        dwell = 8'd1;
        count = 8'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("pre-reset lasers", 32'(lasers), 32'(2'b11));
        check("pre-reset cars", 32'(cars_sent), 32'd1);
        rst = 1'b0;
        #1;
        check("async reset outs", 32'({done, busy, lasers, cars_sent}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post-reset idle", 32'({done, busy, lasers, cars_sent}), 32'd0);

        // loopback through the decoder: 5 entries then 3 exits
        dec_en = 1'b1;
        run_burst("loop entry", 1'b0, 1, 5, -1, -1);
        run_burst("loop exit", 1'b1, 1, 3, -1, -1);
        check("loopback count", 32'(dec_cnt), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/laser_pattern_gen.md
Name: laser_pattern_gen

Overview:
- Transmitter side of the car-counter laser-beam interface.
- Emits the 2-bit `lasers` sequences that the counting FSM decodes:
  - entry: 01 -> 11 -> 10 -> 00
  - exit: 10 -> 11 -> 01 -> 00
- Emits a programmable number of cars, each phase held for a programmable dwell.
- Drives the counter FSM on-board for self-test, and stands in for the physical sensors in system benches.

Parameters:
- DWELL_W, 8, width of per-phase dwell count in clk cycles
- CNT_W, 8, width of car-count request and cars_sent

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  request a burst; sampled only in IDLE
- dir  input  1  0 = entry sequence, 1 = exit sequence; latched at start
- dwell  input  DWELL_W  cycles per phase; latched at start; 0 treated as 1
- count  input  CNT_W  cars to emit; latched at start
- abort  input  1  terminate burst immediately
- lasers  output  2  beam pattern to the counter FSM (bit0 = beam A, bit1 = beam B)
- busy  output  1  high while a burst is in progress
- done  output  1  one-cycle pulse when a burst completes normally
- cars_sent  output  CNT_W  cars fully emitted in current/last burst

Behaviour:
- Reset (rst=0, async): state=IDLE, lasers=00, busy=0, done=0, cars_sent=0. The reset state holds until the first clk edge after rst returns to 1.
- States: IDLE, PH1, PH2, PH3, GAP. All outputs are registered.
- Patterns:
  - dir=0: PH1=01, PH2=11, PH3=10, GAP=00
  - dir=1: PH1=10, PH2=11, PH3=01, GAP=00
- Effective dwell: D = (dwell==0) ? 1 : dwell.
- Start, count≠0, at edge T0 in IDLE:
  - at edge T0: latch dir/D/count, cars_sent<=0, busy<=1, lasers<=PH1 pattern, state<=PH1
  - lasers changes at edges T0+D (PH2), T0+2D (PH3), T0+3D (GAP)
  - each phase is held exactly D cycles
- End of GAP (edge T0+4D for car 1):
  - cars_sent<=cars_sent+1
  - if the new value == latched count: state<=IDLE, busy<=0, done<=1 for exactly one cycle
  - otherwise: state<=PH1, next car begins with the same dir/D
- Burst length: count*4*D cycles of busy.
- start with count==0 in IDLE: no laser activity, busy stays 0, cars_sent<=0, done pulses at the next edge.
- start while busy: ignored. Input changes while busy are ignored; latched values are used.
- abort (any state except IDLE):
  - at the next edge: lasers<=00, state<=IDLE, busy<=0
  - no done pulse; cars_sent holds completed cars only
  - abort has priority over a GAP completion on the same edge
- abort in IDLE: no effect. start and abort together in IDLE: abort wins, start is dropped.
- Dwell counter: DWELL_W bits, loaded with D-1 at each phase entry, phase advances when it reaches 0. No wrap past 0.
- cars_sent does not wrap within a burst (max = count ≤ 2^CNT_W-1).
- lasers never glitches: exactly one bit changes per phase transition, except GAP->PH1 (00->01 or 00->10, still one bit).
- Async reset mid-burst: all outputs return to reset values immediately; the partial car is discarded.

Decomposition:
- Shared package laser_pkg:
  - state enum typedef (IDLE, PH1, PH2, PH3, GAP)
  - 2-bit pattern localparams (LAS_NONE=00, LAS_A=01, LAS_AB=11, LAS_B=10)
  - DIR_ENTRY/DIR_EXIT constants
  - the counter FSM imports the same pattern constants
- One natural sub-module: phase_timer (loadable DWELL_W down-counter with load/expire), reused for the display refresh divider.

Test Plan:
1. start, dir=0, dwell=3, count=1 -> lasers 01×3, 11×3, 10×3, 00×3 cycles; busy high 12 cycles; done pulse at edge T0+12; cars_sent=1.
2. start, dir=1, dwell=2, count=3 -> sequence 10,11,01,00 repeated 3 times at 2 cycles/phase; busy 24 cycles; cars_sent 1,2,3 at edges T0+8/16/24; single done pulse.
3. dwell=0, count=2, dir=0 -> each phase 1 cycle; busy 8 cycles; cars_sent=2; done once.
4. start count=2, dwell=4; abort asserted at cycle T0+10 (car 1 in PH3) -> lasers=00 next edge, busy=0, no done, cars_sent=0. A new start then runs normally.
5. start re-pulsed with dir=1 and count=9 mid-burst -> ignored; original dir=0/count completes unchanged. start with count=0 -> lasers stay 00, done one cycle, busy stays 0.
6. rst pulled low mid-PH2 -> lasers=00, busy=0, cars_sent=0 immediately (before next clk). Loopback into the counter FSM: count=5 entry then 3 exit -> displayed count 2.
